// File: rtl/front_pipe_regs.sv
// front_pipe_regs: PC, IF/ID and ID/EX pipeline registers for the RV32I
// front end, with decode-stage register extraction and event counters.
//
// Ports:
//   clk, rst              core clock, async active-high reset
//   instr_F, pc_target_E  fetched instruction, execute redirect target
//   Stall, Flush          hazard unit hold / squash requests
//   pc_F                  fetch PC
//   instr_D, pc_D, valid_D, RS1D, RS2D, RDD      decode stage
//   pc_E, RS1E, RS2E, RDE, rd_en, w_enE, valid_E execute stage
//   stall_cnt, flush_cnt  saturating event counters

package front_pipe_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ld;
    logic        wr;
    logic        valid;
  } id_ex_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ld;
    logic       wr;
  } dec_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

endpackage

module front_pipe_regs
  import front_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_F,
  input  logic [31:0]      pc_target_E,
  input  logic             Stall,
  input  logic             Flush,
  output logic [31:0]      pc_F,
  output logic [31:0]      instr_D,
  output logic [31:0]      pc_D,
  output logic             valid_D,
  output logic [4:0]       RS1D,
  output logic [4:0]       RS2D,
  output logic [4:0]       RDD,
  output logic [31:0]      pc_E,
  output logic [4:0]       RS1E,
  output logic [4:0]       RS2E,
  output logic [4:0]       RDE,
  output logic             rd_en,
  output logic             w_enE,
  output logic             valid_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      pc_q;
  if_id_t           id_q;
  id_ex_t           ex_q;
  dec_t             dec;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Flush dominates Stall; the three cases are exclusive.
  logic do_flush;
  logic do_hold;
  logic do_adv;

  assign do_flush = Flush;
  assign do_hold  = Stall & ~Flush;
  assign do_adv   = ~Stall & ~Flush;

  // Decode: classify opcode by which register fields it uses.
  logic [6:0] opc;
  logic       fmt_r;
  logic       fmt_i;
  logic       fmt_sb;
  logic       fmt_uj;

  assign opc    = id_q.instr[6:0];
  assign fmt_r  = (opc == OP_R);
  assign fmt_i  = (opc == OP_IALU) |
                  (opc == OP_LOAD) |
                  (opc == OP_JALR);
  assign fmt_sb = (opc == OP_STORE) |
                  (opc == OP_BR);
  assign fmt_uj = (opc == OP_LUI) |
                  (opc == OP_AUIPC) |
                  (opc == OP_JAL);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      fmt_r: begin
        dec.rs1 = id_q.instr[19:15];
        dec.rs2 = id_q.instr[24:20];
        dec.rd  = id_q.instr[11:7];
      end
      fmt_i: begin
        dec.rs1 = id_q.instr[19:15];
        dec.rd  = id_q.instr[11:7];
      end
      fmt_sb: begin
        dec.rs1 = id_q.instr[19:15];
        dec.rs2 = id_q.instr[24:20];
      end
      fmt_uj: begin
        dec.rd  = id_q.instr[11:7];
      end
      default: begin
        dec = '0;
      end
    endcase
    dec.ld = (opc == OP_LOAD);
    // x0 destinations never count as writes
    dec.wr = (fmt_r | fmt_i | fmt_uj) &
             (dec.rd != 5'd0);
    if (!id_q.valid) begin
      dec = '0;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      unique case (1'b1)
        do_flush: pc_q <= pc_target_E;
        do_hold:  pc_q <= pc_q;
        do_adv:   pc_q <= pc_q + 32'd4;
        default:  pc_q <= pc_q;
      endcase
    end
  end

  // IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q <= '{instr: NOP_INSTR,
                pc: 32'd0,
                valid: 1'b0};
    end else begin
      unique case (1'b1)
        do_flush: begin
          id_q <= '{instr: NOP_INSTR,
                    pc: 32'd0,
                    valid: 1'b0};
        end
        do_hold: id_q <= id_q;
        do_adv: begin
          id_q <= '{instr: instr_F,
                    pc: pc_q,
                    valid: 1'b1};
        end
        default: id_q <= id_q;
      endcase
    end
  end

  // ID/EX register: stall and flush both insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (do_adv) begin
      ex_q <= '{pc: id_q.pc,
                rs1: dec.rs1,
                rs2: dec.rs2,
                rd: dec.rd,
                ld: dec.ld,
                wr: dec.wr,
                valid: id_q.valid};
    end else begin
      ex_q <= '0;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (do_hold && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (do_flush && !(&flush_q)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign pc_F      = pc_q;
  assign instr_D   = id_q.instr;
  assign pc_D      = id_q.pc;
  assign valid_D   = id_q.valid;
  assign RS1D      = dec.rs1;
  assign RS2D      = dec.rs2;
  assign RDD       = dec.rd;
  assign pc_E      = ex_q.pc;
  assign RS1E      = ex_q.rs1;
  assign RS2E      = ex_q.rs2;
  assign RDE       = ex_q.rd;
  assign rd_en     = ex_q.ld;
  assign w_enE     = ex_q.wr;
  assign valid_E   = ex_q.valid;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_front_pipe_regs.sv
// tb_front_pipe_regs: directed table, corner sequences and randomized
// model comparison for front_pipe_regs.

module tb_front_pipe_regs;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADDI3 = 32'h0030_8193;
  localparam logic [31:0] ADDI4 = 32'h0041_0213;
  localparam logic [31:0] LW    = 32'h0001_2283;
  localparam logic [31:0] ADD   = 32'h0012_8333;
  localparam logic [31:0] LUI   = 32'h1234_53B7;
  localparam logic [31:0] SW    = 32'h0031_2423;

  logic        clk;
  logic        rst;
  logic [31:0] instr_F;
  logic [31:0] pc_target_E;
  logic        Stall;
  logic        Flush;

  logic [31:0] pc_F, instr_D, pc_D, pc_E;
  logic        valid_D, valid_E, rd_en, w_enE;
  logic [4:0]  RS1D, RS2D, RDD, RS1E, RS2E, RDE;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_pc_F, s_instr_D, s_pc_D, s_pc_E;
  logic        s_valid_D, s_valid_E, s_rd_en, s_w_enE;
  logic [4:0]  s_RS1D, s_RS2D, s_RDD, s_RS1E, s_RS2E, s_RDE;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  front_pipe_regs dut (
    .clk(clk), .rst(rst), .instr_F(instr_F),
    .pc_target_E(pc_target_E), .Stall(Stall),
    .Flush(Flush), .pc_F(pc_F), .instr_D(instr_D),
    .pc_D(pc_D), .valid_D(valid_D), .RS1D(RS1D),
    .RS2D(RS2D), .RDD(RDD), .pc_E(pc_E),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
    .rd_en(rd_en), .w_enE(w_enE), .valid_E(valid_E),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // narrow-counter instance to exercise saturation quickly
  front_pipe_regs #(
    .RESET_PC(32'h0000_0080), .CNT_W(3)
  ) dut_s (
    .clk(clk), .rst(rst), .instr_F(instr_F),
    .pc_target_E(pc_target_E), .Stall(Stall),
    .Flush(Flush), .pc_F(s_pc_F), .instr_D(s_instr_D),
    .pc_D(s_pc_D), .valid_D(s_valid_D), .RS1D(s_RS1D),
    .RS2D(s_RS2D), .RDD(s_RDD), .pc_E(s_pc_E),
    .RS1E(s_RS1E), .RS2E(s_RS2E), .RDE(s_RDE),
    .rd_en(s_rd_en), .w_enE(s_w_enE),
    .valid_E(s_valid_E),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st, fl;
    logic [31:0] tgt, ins, pc, insd;
    logic        vd;
    logic [4:0]  s1d, s2d, rdd;
    logic        ve;
    logic [4:0]  s1e, s2e, rde;
    logic        lde, we;
    logic [15:0] sc, fc;
  } vec_t;

  vec_t tbl[$];

  task automatic row(
    input int st, input int fl,
    input logic [31:0] tgt, input logic [31:0] ins,
    input logic [31:0] pc, input logic [31:0] insd,
    input int vd, input int s1d, input int s2d,
    input int rdd, input int ve, input int s1e,
    input int s2e, input int rde, input int lde,
    input int we, input int sc, input int fc);
    vec_t v;
    v.st = 1'(st);   v.fl = 1'(fl);
    v.tgt = tgt;     v.ins = ins;
    v.pc = pc;       v.insd = insd;
    v.vd = 1'(vd);
    v.s1d = 5'(s1d); v.s2d = 5'(s2d);
    v.rdd = 5'(rdd); v.ve = 1'(ve);
    v.s1e = 5'(s1e); v.s2e = 5'(s2e);
    v.rde = 5'(rde); v.lde = 1'(lde);
    v.we = 1'(we);
    v.sc = 16'(sc);  v.fc = 16'(fc);
    tbl.push_back(v);
  endtask

  // reference model state
  logic [31:0] m_pc, md_ins, md_pc, me_pc;
  logic        md_v, me_v, me_ld, me_wr;
  logic [4:0]  me_r1, me_r2, me_rd;
  int          m_sc, m_fc;

  function automatic void mdec(
    input  logic [31:0] ins, input logic v,
    output logic [4:0] r1, output logic [4:0] r2,
    output logic [4:0] rd,
    output logic ld, output logic wr);
    logic u1, u2, ud;
    case (ins[6:0])
      7'b0110011:
        {u1, u2, ud} = 3'b111;
      7'b0010011, 7'b0000011, 7'b1100111:
        {u1, u2, ud} = 3'b101;
      7'b0100011, 7'b1100011:
        {u1, u2, ud} = 3'b110;
      7'b0110111, 7'b0010111, 7'b1101111:
        {u1, u2, ud} = 3'b001;
      default:
        {u1, u2, ud} = 3'b000;
    endcase
    r1 = (v && u1) ? ins[19:15] : 5'd0;
    r2 = (v && u2) ? ins[24:20] : 5'd0;
    rd = (v && ud) ? ins[11:7]  : 5'd0;
    ld = v && (ins[6:0] == 7'b0000011);
    wr = v && ud && (rd != 5'd0);
  endfunction

  task automatic m_reset();
    m_pc = 32'd0;  md_ins = NOP; md_pc = 32'd0;
    md_v = 1'b0;   me_pc = 32'd0; me_v = 1'b0;
    me_r1 = 5'd0;  me_r2 = 5'd0; me_rd = 5'd0;
    me_ld = 1'b0;  me_wr = 1'b0;
    m_sc = 0;      m_fc = 0;
  endtask

  task automatic m_edge(input logic st, input logic fl,
                        input logic [31:0] tgt,
                        input logic [31:0] ins);
    logic [4:0] r1, r2, rd;
    logic ld, wr;
    mdec(md_ins, md_v, r1, r2, rd, ld, wr);
    if (fl || st) begin
      me_pc = 0; me_v = 0; me_r1 = 0; me_r2 = 0;
      me_rd = 0; me_ld = 0; me_wr = 0;
    end else begin
      me_pc = md_pc; me_v = md_v; me_r1 = r1;
      me_r2 = r2; me_rd = rd; me_ld = ld; me_wr = wr;
    end
    if (fl) begin
      m_pc = tgt; md_ins = NOP; md_pc = 0; md_v = 0;
      m_fc++;
    end else if (st) begin
      m_sc++;
    end else begin
      md_ins = ins; md_pc = m_pc; md_v = 1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] sat(input int c,
                                      input int mx);
    return (c > mx) ? mx : c;
  endfunction

  task automatic m_check();
    logic [4:0] r1, r2, rd;
    logic ld, wr;
    mdec(md_ins, md_v, r1, r2, rd, ld, wr);
    chk("rnd pc_F", pc_F, m_pc);
    chk("rnd instr_D", instr_D, md_ins);
    chk("rnd pc_D", pc_D, md_pc);
    chk("rnd valid_D", valid_D, md_v);
    chk("rnd RS1D", RS1D, r1);
    chk("rnd RS2D", RS2D, r2);
    chk("rnd RDD", RDD, rd);
    chk("rnd pc_E", pc_E, me_pc);
    chk("rnd valid_E", valid_E, me_v);
    chk("rnd RS1E", RS1E, me_r1);
    chk("rnd RS2E", RS2E, me_r2);
    chk("rnd RDE", RDE, me_rd);
    chk("rnd rd_en", rd_en, me_ld);
    chk("rnd w_enE", w_enE, me_wr);
    chk("rnd stall_cnt", stall_cnt, sat(m_sc, 65535));
    chk("rnd flush_cnt", flush_cnt, sat(m_fc, 65535));
    chk("rnd s_stall_cnt", s_stall_cnt, sat(m_sc, 7));
    chk("rnd s_flush_cnt", s_flush_cnt, sat(m_fc, 7));
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011,
            7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b0000000};
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    rst = 1'b1;
    instr_F = NOP;
    pc_target_E = 32'd0;
    Stall = 1'b0;
    Flush = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst pc_F", pc_F, 32'd0);
    chk("rst instr_D", instr_D, NOP);
    chk("rst valid_D", valid_D, 1'b0);
    chk("rst valid_E", valid_E, 1'b0);
    chk("rst w_enE", w_enE, 1'b0);
    chk("rst s_pc_F", s_pc_F, 32'h80);
    rst = 1'b0;

    //  st fl tgt     ins    pc      insd   vd s1 s2 rd
    //  ve s1e s2e rde ld we sc fc
    row(0, 0, 0, ADDI1, 32'h04, ADDI1, 1, 0, 0, 1,
        0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, ADDI2, 32'h08, ADDI2, 1, 0, 0, 2,
        1, 0, 0, 1, 0, 1, 0, 0);
    row(0, 0, 0, ADDI3, 32'h0C, ADDI3, 1, 1, 0, 3,
        1, 0, 0, 2, 0, 1, 0, 0);
    row(0, 0, 0, ADDI4, 32'h10, ADDI4, 1, 2, 0, 4,
        1, 1, 0, 3, 0, 1, 0, 0);
    row(0, 0, 0, LW, 32'h14, LW, 1, 2, 0, 5,
        1, 2, 0, 4, 0, 1, 0, 0);
    row(0, 0, 0, ADD, 32'h18, ADD, 1, 5, 1, 6,
        1, 2, 0, 5, 1, 1, 0, 0);
    row(1, 0, 0, ADDI1, 32'h18, ADD, 1, 5, 1, 6,
        0, 0, 0, 0, 0, 0, 1, 0);
    row(0, 0, 0, LUI, 32'h1C, LUI, 1, 0, 0, 7,
        1, 5, 1, 6, 0, 1, 1, 0);
    row(0, 0, 0, SW, 32'h20, SW, 1, 2, 3, 0,
        1, 0, 0, 7, 0, 1, 1, 0);
    row(0, 1, 32'h100, ADDI1, 32'h100, NOP, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 1, 1);
    row(0, 0, 0, ADDI2, 32'h104, ADDI2, 1, 0, 0, 2,
        0, 0, 0, 0, 0, 0, 1, 1);
    row(1, 1, 32'h200, ADDI3, 32'h200, NOP, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 1, 2);
    row(1, 0, 0, ADDI4, 32'h200, NOP, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 2, 2);

    foreach (tbl[i]) begin
      Stall = tbl[i].st;
      Flush = tbl[i].fl;
      pc_target_E = tbl[i].tgt;
      instr_F = tbl[i].ins;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("r%0d pc_F", i), pc_F, tbl[i].pc);
      chk($sformatf("r%0d instr_D", i), instr_D,
          tbl[i].insd);
      chk($sformatf("r%0d valid_D", i), valid_D,
          tbl[i].vd);
      chk($sformatf("r%0d RS1D", i), RS1D, tbl[i].s1d);
      chk($sformatf("r%0d RS2D", i), RS2D, tbl[i].s2d);
      chk($sformatf("r%0d RDD", i), RDD, tbl[i].rdd);
      chk($sformatf("r%0d valid_E", i), valid_E,
          tbl[i].ve);
      chk($sformatf("r%0d RS1E", i), RS1E, tbl[i].s1e);
      chk($sformatf("r%0d RS2E", i), RS2E, tbl[i].s2e);
      chk($sformatf("r%0d RDE", i), RDE, tbl[i].rde);
      chk($sformatf("r%0d rd_en", i), rd_en, tbl[i].lde);
      chk($sformatf("r%0d w_enE", i), w_enE, tbl[i].we);
      chk($sformatf("r%0d stall_cnt", i), stall_cnt,
          tbl[i].sc);
      chk($sformatf("r%0d flush_cnt", i), flush_cnt,
          tbl[i].fc);
    end

    // asynchronous reset between edges
    Stall = 1'b0;
    Flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid rst pc_F", pc_F, 32'd0);
    chk("mid rst s_pc_F", s_pc_F, 32'h80);
    chk("mid rst valid_D", valid_D, 1'b0);
    chk("mid rst valid_E", valid_E, 1'b0);
    chk("mid rst stall_cnt", stall_cnt, 16'd0);
    chk("mid rst flush_cnt", flush_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // PC wrap at the top of the address space
    Flush = 1'b1;
    pc_target_E = 32'hFFFF_FFFC;
    @(posedge clk);
    @(negedge clk);
    chk("wrap pc_F0", pc_F, 32'hFFFF_FFFC);
    Flush = 1'b0;
    instr_F = ADD;
    @(posedge clk);
    @(negedge clk);
    chk("wrap pc_F1", pc_F, 32'd0);
    chk("wrap pc_D", pc_D, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    chk("wrap pc_E", pc_E, 32'hFFFF_FFFC);
    chk("wrap RS1E", RS1E, 32'd5);

    // randomized run against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic st, fl;
      logic [31:0] tgt, ins;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 4) == 0);
      tgt = $urandom;
      ins = gen_instr();
      Stall = st;
      Flush = fl;
      pc_target_E = tgt;
      instr_F = ins;
      @(posedge clk);
      m_edge(st, fl, tgt, ins);
      @(negedge clk);
      m_check();
    end

    // stall counter saturation at full width
    Stall = 1'b0;
    Flush = 1'b0;
    do_reset();
    Stall = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat stall_cnt FFFE", stall_cnt, 16'hFFFE);
    chk("sat s_stall_cnt", s_stall_cnt, 3'd7);
    chk("sat flush_cnt", flush_cnt, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat stall_cnt FFFF", stall_cnt, 16'hFFFF);
    chk("sat pc_F held", pc_F, 32'd0);
    Stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
